// File: rtl/c64_audio_pkg.sv
// Shared audio types and helpers for the C64 core's audio output path.
package c64_audio_pkg;

  localparam int AUDIO_DW_DEFAULT = 16;

  typedef struct packed {
    logic [AUDIO_DW_DEFAULT-1:0] l;
    logic [AUDIO_DW_DEFAULT-1:0] r;
  } stereo_t;

  // One I2S frame is 2*dw BCK periods of 2*clk_div clk32 cycles each.
  function automatic int frame_clks(input int clk_div, input int dw);
    return 4 * clk_div * dw;
  endfunction

endpackage

// File: rtl/c64_i2s_clkgen.sv
// I2S bit-clock divider: BCK toggles every CLK_DIV clk32 cycles, with
// one-cycle strobes marking the clk32 edge on which BCK rises or falls.
module c64_i2s_clkgen
  import c64_audio_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk32,
  input  logic reset,
  input  logic enable,
  output logic bck,
  output logic bck_rise,
  output logic bck_fall
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_reg;
  logic          bck_reg;
  logic          terminal;

  // Strobes are combinational so consumers update on the same edge as BCK.
  assign terminal = enable && (div_reg == TERM);
  assign bck_rise = terminal && !bck_reg;
  assign bck_fall = terminal && bck_reg;
  assign bck      = bck_reg;

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      div_reg <= '0;
      bck_reg <= 1'b0;
    end else if (!enable) begin
      div_reg <= '0;
      bck_reg <= 1'b0;
    end else if (terminal) begin
      div_reg <= '0;
      bck_reg <= ~bck_reg;
    end else begin
      div_reg <= div_reg + CW'(1);
    end
  end

endmodule

// File: rtl/c64_i2s_tx.sv
// I2S transmitter: one-pair holding buffer feeding a frame register that is
// shifted out MSB first with the standard one-BCK data delay after LRCK.
module c64_i2s_tx
  import c64_audio_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int AUDIO_DW = AUDIO_DW_DEFAULT
) (
  input  logic                clk32,
  input  logic                reset,
  input  logic                enable,
  input  logic [AUDIO_DW-1:0] left,
  input  logic [AUDIO_DW-1:0] right,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                underrun,
  output logic                i2s_bck,
  output logic                i2s_lrck,
  output logic                i2s_data
);

  localparam int SLOTS = 2 * AUDIO_DW;
  localparam int SW = $clog2(SLOTS);
  localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);

  logic                bck_fall;
  logic                bck_rise_unused;
  logic [SW-1:0]       slot_reg;
  logic [SW-1:0]       slot_next;
  logic [SW-1:0]       bit_idx;
  logic [AUDIO_DW-1:0] hold_l_reg;
  logic [AUDIO_DW-1:0] hold_r_reg;
  logic [AUDIO_DW-1:0] frame_l_reg;
  logic [AUDIO_DW-1:0] frame_r_reg;
  logic [SLOTS-1:0]    frame_word;
  logic                hold_full_reg;
  logic                lrck_reg;
  logic                data_reg;
  logic                underrun_reg;
  logic                load;
  logic                accept;
  logic                lrck_next;
  logic                data_next;

  c64_i2s_clkgen #(
    .CLK_DIV(CLK_DIV)
  ) u_clkgen (
    .clk32    (clk32),
    .reset    (reset),
    .enable   (enable),
    .bck      (i2s_bck),
    .bck_rise (bck_rise_unused),
    .bck_fall (bck_fall)
  );

  // Slot n>=1 carries frame_word[SLOTS-n]; slot 0 repeats the old R LSB,
  // taken before this edge's load replaces the frame register.
  always_comb begin
    slot_next  = (slot_reg == LAST_SLOT) ? '0 : slot_reg + SW'(1);
    load       = bck_fall && (slot_reg == LAST_SLOT);
    accept     = sample_valid && !hold_full_reg;
    frame_word = {frame_l_reg, frame_r_reg};
    bit_idx    = SW'(SLOTS - int'(slot_next));
    lrck_next  = (slot_next >= SW'(AUDIO_DW));
    data_next  = (slot_next == '0) ? frame_r_reg[0] : frame_word[bit_idx];
  end

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      slot_reg     <= LAST_SLOT;
      lrck_reg     <= 1'b1;
      data_reg     <= 1'b0;
      underrun_reg <= 1'b0;
    end else if (!enable) begin
      slot_reg     <= LAST_SLOT;
      lrck_reg     <= 1'b1;
      data_reg     <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      underrun_reg <= load && !hold_full_reg;
      if (bck_fall) begin
        slot_reg <= slot_next;
        lrck_reg <= lrck_next;
        data_reg <= data_next;
      end
    end
  end

  // A pair accepted on a load edge is never bypassed into the frame.
  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      hold_full_reg <= 1'b0;
      hold_l_reg    <= '0;
      hold_r_reg    <= '0;
      frame_l_reg   <= '0;
      frame_r_reg   <= '0;
    end else begin
      if (accept) begin
        hold_full_reg <= 1'b1;
        hold_l_reg    <= left;
        hold_r_reg    <= right;
      end else if (load && hold_full_reg) begin
        hold_full_reg <= 1'b0;
      end
      if (load && hold_full_reg) begin
        frame_l_reg <= hold_l_reg;
        frame_r_reg <= hold_r_reg;
      end
    end
  end

  assign sample_ready = !hold_full_reg;
  assign underrun     = underrun_reg;
  assign i2s_lrck     = lrck_reg;
  assign i2s_data     = data_reg;

endmodule
